// File: rtl/gcd_stream.sv
// Binary (Stein) GCD engine with valid/ready operand and result channels.
// Define GCD_ITER_CNT_EN to add the iter_cnt port reporting CALC cycles per result.
module gcd_stream #(
  parameter int WL = 16
`ifdef GCD_ITER_CNT_EN
  ,
  parameter int CW = $clog2(2*WL+2)
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WL-1:0] op_a,
  input  logic [WL-1:0] op_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WL-1:0] res
`ifdef GCD_ITER_CNT_EN
  ,
  output logic [CW-1:0] iter_cnt
`endif
);

  localparam int KW = $clog2(WL);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [WL-1:0]   a_q, a_d;
  logic [WL-1:0]   b_q, b_d;
  logic [KW-1:0]   k_q, k_d;
  logic [WL-1:0]   res_q, res_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
`ifdef GCD_ITER_CNT_EN
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   iter_q, iter_d;
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    k_d         = k_q;
    res_d       = res_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef GCD_ITER_CNT_EN
    cnt_d       = cnt_q;
    iter_d      = iter_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = op_a;
          b_d        = op_b;
          k_d        = '0;
          in_ready_d = 1'b0;
`ifdef GCD_ITER_CNT_EN
          cnt_d      = '0;
`endif
          // A zero operand needs no iteration: gcd(x,0) = x.
          if (op_a == '0 || op_b == '0) begin
            res_d       = op_a | op_b;
            out_valid_d = 1'b1;
            state_d     = DONE;
`ifdef GCD_ITER_CNT_EN
            iter_d      = '0;
`endif
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
`ifdef GCD_ITER_CNT_EN
        cnt_d = cnt_q + CW'(1);
`endif
        if (a_q == b_q) begin
          res_d       = a_q << k_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
`ifdef GCD_ITER_CNT_EN
          iter_d      = cnt_q + CW'(1);
`endif
        end else if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + KW'(1);
        end else if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q > b_q) begin
          a_d = (a_q - b_q) >> 1;
        end else begin
          b_d = (b_q - a_q) >> 1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef GCD_ITER_CNT_EN
      cnt_q       <= '0;
      iter_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      k_q         <= k_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef GCD_ITER_CNT_EN
      cnt_q       <= cnt_d;
      iter_q      <= iter_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign res       = res_q;
`ifdef GCD_ITER_CNT_EN
  assign iter_cnt  = iter_q;
`endif

endmodule

// File: tb/tb_gcd_stream.sv
// Bench for gcd_stream: WL=16 and WL=8 instances, directed table, reset and
// backpressure sequences, and randomized pairs against a reference model.
module tb_gcd_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv16, ir16, ov16, ordy16;
  logic [15:0] a16, b16, r16;
  logic        iv8, ir8, ov8, ordy8;
  logic [7:0]  a8, b8, r8;
`ifdef GCD_ITER_CNT_EN
  logic [5:0]  ic16;
  logic [4:0]  ic8;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gcd_stream #(.WL(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
    .op_a(a16), .op_b(b16), .out_valid(ov16), .out_ready(ordy16), .res(r16)
`ifdef GCD_ITER_CNT_EN
    , .iter_cnt(ic16)
`endif
  );

  gcd_stream #(.WL(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .op_a(a8), .op_b(b8), .out_valid(ov8), .out_ready(ordy8), .res(r8)
`ifdef GCD_ITER_CNT_EN
    , .iter_cnt(ic8)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_gcd(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Number of CALC cycles the Stein rules take for a pair.
  function automatic int ref_steps(input int x, input int y);
    int n;
    if (x == 0 || y == 0) return 0;
    n = 0;
    forever begin
      n++;
      if (x == y) return n;
      if (x % 2 == 0 && y % 2 == 0) begin x = x / 2; y = y / 2; end
      else if (x % 2 == 0) x = x / 2;
      else if (y % 2 == 0) y = y / 2;
      else if (x > y) x = (x - y) / 2;
      else y = (y - x) / 2;
    end
  endfunction

  task automatic run_op(input bit s8, input int a, input int b, input int stall,
                        output int r, output int lat, output int it);
    int w;
    w = 0;
    while (!(s8 ? ir8 : ir16) && w < 200) begin @(negedge clk); w++; end
    if (w >= 200) check("in_ready_timeout", 0, 1);
    if (s8) begin a8 = a[7:0]; b8 = b[7:0]; iv8 = 1'b1; end
    else begin a16 = a[15:0]; b16 = b[15:0]; iv16 = 1'b1; end
    @(negedge clk);
    iv8 = 1'b0; iv16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 1;
    while (!(s8 ? ov8 : ov16) && lat < 200) begin @(negedge clk); lat++; end
    if (lat >= 200) check("out_valid_timeout", 0, 1);
    r = s8 ? int'(r8) : int'(r16);
`ifdef GCD_ITER_CNT_EN
    it = s8 ? int'(ic8) : int'(ic16);
`else
    it = -1;
`endif
    for (int i = 0; i < stall; i++) begin
      // New operands offered while a result waits must be ignored.
      if (s8) iv8 = 1'b1; else iv16 = 1'b1;
      @(negedge clk);
      check("hold_res", s8 ? r8 : r16, r);
      check("hold_out_valid", s8 ? ov8 : ov16, 1);
      check("hold_in_ready", s8 ? ir8 : ir16, 0);
    end
    iv8 = 1'b0; iv16 = 1'b0;
    if (s8) ordy8 = 1'b1; else ordy16 = 1'b1;
    @(negedge clk);
    ordy8 = 1'b0; ordy16 = 1'b0;
    check("in_ready_after_hs", s8 ? ir8 : ir16, 1);
    check("out_valid_after_hs", s8 ? ov8 : ov16, 0);
    check("res_kept_after_hs", s8 ? r8 : r16, r);
  endtask

  typedef struct {
    bit s8;
    int a;
    int b;
    int stall;
    int res;
    int iter;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int r, lat, it, a, b, mode, st, w, ok;
    bit s8;

    rst = 1'b1;
    iv16 = 0; ordy16 = 0; a16 = 0; b16 = 0;
    iv8 = 0; ordy8 = 0; a8 = 0; b8 = 0;
    repeat (3) @(negedge clk);
    check("rst_in_ready16", ir16, 1);
    check("rst_out_valid16", ov16, 0);
    check("rst_res16", r16, 0);
    check("rst_in_ready8", ir8, 1);
    check("rst_out_valid8", ov8, 0);
    check("rst_res8", r8, 0);
`ifdef GCD_ITER_CNT_EN
    check("rst_iter16", ic16, 0);
    check("rst_iter8", ic8, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    vecs = '{
      '{0, 12, 18, 0, 6, 4},
      '{0, 17, 17, 0, 17, 1},
      '{0, 0, 9, 0, 9, 0},
      '{0, 0, 0, 1, 0, 0},
      '{0, 48, 36, 5, 12, 6},
      '{0, 21, 14, 2, 7, 3},
      '{0, 65535, 1, 0, 1, 16},
      '{0, 32768, 32768, 0, 32768, 1},
      '{1, 255, 1, 0, 1, 8},
      '{1, 128, 64, 3, 64, 8},
      '{1, 255, 255, 0, 255, 1},
      '{1, 0, 200, 0, 200, 0},
      '{0, 12, 18, 0, 6, 4}
    };
    foreach (vecs[i]) begin
      run_op(vecs[i].s8, vecs[i].a, vecs[i].b, vecs[i].stall, r, lat, it);
      check($sformatf("vec%0d_res", i), r, vecs[i].res);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].iter + 1);
`ifdef GCD_ITER_CNT_EN
      check($sformatf("vec%0d_iter", i), it, vecs[i].iter);
`endif
    end

    // Reset during the second CALC cycle of (12,18) discards the operation.
    a16 = 16'd12; b16 = 16'd18; iv16 = 1'b1;
    @(negedge clk);
    iv16 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", ir16, 1);
    check("midrst_out_valid", ov16, 0);
    check("midrst_res", r16, 0);
    ok = 1;
    repeat (6) begin @(negedge clk); if (ov16 !== 1'b0) ok = 0; end
    check("midrst_no_output", ok, 1);
    run_op(0, 21, 14, 0, r, lat, it);
    check("after_rst_res", r, 7);
    check("after_rst_latency", lat, 4);

    for (int i = 0; i < 1500; i++) begin
      s8 = (i % 3 == 0);
      mode = $urandom_range(0, 9);
      w = s8 ? 8 : 16;
      a = int'($urandom & (s8 ? 32'hFF : 32'hFFFF));
      b = int'($urandom & (s8 ? 32'hFF : 32'hFFFF));
      if (mode == 0) a = 0;
      if (mode == 1) b = 0;
      if (mode == 2) b = a;
      if (mode == 3) begin
        a = (a << 3) & (s8 ? 32'hFF : 32'hFFFF);
        b = (b << 2) & (s8 ? 32'hFF : 32'hFFFF);
      end
      st = $urandom_range(0, 3);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(s8, a, b, st, r, lat, it);
      check($sformatf("rnd%0d_res(%0d,%0d)", i, a, b), r, ref_gcd(a, b));
      check($sformatf("rnd%0d_latency(%0d,%0d)", i, a, b), lat, ref_steps(a, b) + 1);
      check($sformatf("rnd%0d_calc_bound", i), (lat - 1) <= 2 * w + 1, 1);
`ifdef GCD_ITER_CNT_EN
      check($sformatf("rnd%0d_iter(%0d,%0d)", i, a, b), it, ref_steps(a, b));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
